// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard unit (slave).
// Signal names follow the pipeline stage suffix scheme (D/E/M/W).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) ();
  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic [REG_AW-1:0] rs1E;
  logic [REG_AW-1:0] rs2E;
  logic [REG_AW-1:0] rdE;
  logic [REG_AW-1:0] rdM;
  logic [REG_AW-1:0] rdW;
  logic              regwriteM;
  logic              regwriteW;
  logic              memrdE;
  logic              memreqM;
  logic              dmem_ready;
  logic              mdu_opE;
  logic              mdu_done;
  logic              pcsrcE;

  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              flushW;
  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;
  logic              mdu_start;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output regwriteM, regwriteW, memrdE, memreqM, dmem_ready, mdu_opE, mdu_done, pcsrcE,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
    input  forwardAE, forwardBE, mdu_start, stall_cnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  regwriteM, regwriteW, memrdE, memreqM, dmem_ready, mdu_opE, mdu_done, pcsrcE,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
    output forwardAE, forwardBE, mdu_start, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard unit: operand forwarding, load-use / memory-wait / MDU stalls,
// branch flushes and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [REG_AW-1:0] RegZero = '0;

  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic memwait, lwstall, mdustall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic mdu_start;
  logic [1:0] fwd_a, fwd_b;

  assign memwait  = hz.memreqM & ~hz.dmem_ready;
  assign lwstall  = hz.memrdE & (hz.rdE != RegZero) & ((hz.rs1D == hz.rdE) | (hz.rs2D == hz.rdE));
  assign mdustall = ((state_q == StIdle) & hz.mdu_opE) | ((state_q == StBusy) & ~hz.mdu_done);

  // M-stage result is younger than W, so it wins when both match.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.regwriteM && hz.rs1E == hz.rdM && hz.rdM != RegZero) begin
      fwd_a = 2'b10;
    end else if (hz.regwriteW && hz.rs1E == hz.rdW && hz.rdW != RegZero) begin
      fwd_a = 2'b01;
    end
    fwd_b = 2'b00;
    if (hz.regwriteM && hz.rs2E == hz.rdM && hz.rdM != RegZero) begin
      fwd_b = 2'b10;
    end else if (hz.regwriteW && hz.rs2E == hz.rdW && hz.rdW != RegZero) begin
      fwd_b = 2'b01;
    end
  end

  // HOLD parks a finished MDU result behind a memory wait; it is not an MDU stall, so once
  // memwait drops EX advances and the op is never relaunched.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hz.mdu_opE && !memwait) state_d = StBusy;
      StBusy:  if (hz.mdu_done) state_d = memwait ? StHold : StIdle;
      StHold:  if (!memwait) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;
    mdu_start = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (memwait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (mdustall) begin
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      flush_m   = 1'b1;
      mdu_start = (state_q == StIdle);
    end else begin
      flush_d = hz.pcsrcE;
      flush_e = hz.pcsrcE | lwstall;
      stall_f = lwstall & ~hz.pcsrcE;
      stall_d = lwstall & ~hz.pcsrcE;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_f && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stallF    = stall_f;
  assign hz.stallD    = stall_d;
  assign hz.stallE    = stall_e;
  assign hz.stallM    = stall_m;
  assign hz.flushD    = flush_d;
  assign hz.flushE    = flush_e;
  assign hz.flushM    = flush_m;
  assign hz.flushW    = flush_w;
  assign hz.forwardAE = fwd_a;
  assign hz.forwardBE = fwd_b;
  assign hz.mdu_start = mdu_start;
  assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning stall-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW  input  REG_AW each  stage source/destination register addresses.
REQ-006 SHALL have ports regwriteM, regwriteW  input  1  the instruction in M/W writes rd.
REQ-007 SHALL have port memrdE  input  1  the instruction in EX is a load.
REQ-008 SHALL have port memreqM  input  1  the instruction in M accesses data memory.
REQ-009 SHALL have port dmem_ready  input  1  data memory completes the M access this cycle.
REQ-010 SHALL have ports mdu_opE  input  1  the instruction in EX is a multi-cycle mul/div; mdu_done  input  1  the MDU result is valid this cycle.
REQ-011 SHALL have port pcsrcE  input  1  a taken branch/jump redirect from EX.
REQ-012 SHALL have ports stallF, stallD, stallE, stallM  output  1  hold the respective pipeline register.
REQ-013 SHALL have ports flushD, flushE, flushM, flushW  output  1  load a bubble into the respective pipeline register.
REQ-014 SHALL have ports forwardAE, forwardBE  output  2  operand select: 00 register file, 01 W result, 10 M result.
REQ-015 SHALL have port mdu_start  output  1  single-cycle MDU launch pulse.
REQ-016 SHALL have port stall_cnt  output  CNT_W  count of cycles with stallF=1.

Function
REQ-017 SHALL compute forwardAE as 10 if regwriteM and rs1E==rdM and rdM!=0, else 01 if regwriteW and rs1E==rdW and rdW!=0, else 00; forwardBE identically on rs2E; M wins over W; purely combinational.
REQ-018 SHALL define memwait = memreqM and not dmem_ready.
REQ-019 SHALL define lwstall = memrdE and rdE!=0 and (rs1D==rdE or rs2D==rdE).
REQ-020 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-021 IDLE: mdu_opE and not memwait -> assert mdu_start for that cycle, go BUSY; otherwise stay.
REQ-022 BUSY: no mdu_done -> stay; mdu_done and not memwait -> IDLE; mdu_done and memwait -> HOLD.
REQ-023 HOLD: not memwait -> IDLE; otherwise stay; mdu_start SHALL NOT assert in HOLD, so the frozen op is never relaunched.
REQ-024 SHALL define mdustall = (state==IDLE and mdu_opE) or (state==BUSY and not mdu_done).
REQ-025 Priority 1, memwait: stallF=stallD=stallE=stallM=1, flushW=1, all other flushes 0.
REQ-026 Priority 2, mdustall without memwait: stallF=stallD=stallE=1, flushM=1, stallM=0.
REQ-027 Priority 3, neither memwait nor mdustall: flushD=pcsrcE; flushE=pcsrcE or lwstall; stallF=stallD=lwstall and not pcsrcE.
REQ-028 SHALL ignore pcsrcE and lwstall while stallE=1; the redirect is acted on when EX advances.
REQ-029 In HOLD, priority 1 rules SHALL apply.
REQ-030 SHALL increment stall_cnt by 1 each cycle stallF=1 and saturate at all-ones without wrapping.
REQ-031 Outputs not named by the active rule SHALL be 0.

Reset
REQ-032 While rst=1: state SHALL be IDLE next cycle, stall_cnt SHALL be 0 next cycle, all stalls 0, mdu_start 0, flushD=flushE=flushM=flushW=1, forwardAE/BE still combinational.
REQ-033 Reset asserted in BUSY or HOLD SHALL abandon the MDU operation; the first cycle after reset SHALL be IDLE.

Verification
REQ-034 SHALL cover: rs1E=5, rdM=5, rdW=5, regwriteM=regwriteW=1 -> forwardAE=10; rdM=0 with regwriteM=1 -> forwardAE=01.
REQ-035 SHALL cover: memrdE=1, rdE=7, rs2D=7 -> one cycle stallF=stallD=1, flushE=1; the same case with rdE=0 -> no stall.
REQ-036 SHALL cover: mdu_opE=1, mdu_done 4 cycles after start -> mdu_start pulses once; stallF/D/E high 4 cycles; flushM high 4 cycles; stall_cnt +4.
REQ-037 SHALL cover: BUSY, mdu_done coincident with memwait held 3 cycles -> HOLD, all four stalls and flushW high, no second mdu_start, IDLE after memwait drops.
REQ-038 SHALL cover: pcsrcE=1 with lwstall=1 -> flushD=flushE=1, stallF=stallD=0; pcsrcE=1 during memwait -> no flushD/flushE.
REQ-039 SHALL cover: CNT_W=4, 20 stall cycles -> stall_cnt=15 held; rst asserted in BUSY -> next cycle IDLE, stall_cnt=0.
